alu_mc: RTL and testbench

8-bit multi-cycle ALU that sits directly downstream of the register file. It consumes the two register read ports as operands and produces a result plus a destination address for write-back into the register file's write port. Logic/add/forward operations complete in one cycle. Multiply is a sequential shift-add that takes WIDTH cycles. A start/busy/valid handshake gates the datapath.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_mul_seq.sv | 51 +++++
 rtl/alu_mc.sv | 122 ++++++++++++
 tb/tb_alu_mc.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the multi-cycle ALU: default width, opcode encodings
// and FSM state encoding.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 8;

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier: latches operands on start_i, performs one
// iteration per cycle while run_i is high, flags the final iteration on last_o.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             run_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] acc_next_o,
    output logic             last_o
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [CW-1:0]    cnt_q;

    // acc_next_o is the value after the current iteration, so the top can
    // capture the product on the same edge as the last iteration.
    always_comb begin
        acc_next_o = b_q[0] ? (acc_q + a_q) : acc_q;
        last_o     = (cnt_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (start_i) begin
            a_q   <= a_i;
            b_q   <= b_i;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (run_i) begin
            acc_q <= acc_next_o;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU feeding register-file write-back: single-cycle FWD/ADD/AND/OR,
// WIDTH-cycle shift-add MUL, registered RESULT/DEST_OUT/ZERO with a VALID pulse.
module alu_mc
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    input  logic [2:0]       SELECT,
    input  logic [2:0]       DEST_IN,
    input  logic             START,
    output logic [WIDTH-1:0] RESULT,
    output logic [2:0]       DEST_OUT,
    output logic             ZERO,
    output logic             BUSY,
    output logic             VALID
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic [2:0]       dest_q, dest_d;
    logic [2:0]       mdest_q, mdest_d;
    logic             valid_q, valid_d;

    logic             mul_start;
    logic             mul_run;
    logic [WIDTH-1:0] mul_acc_next;
    logic             mul_last;
    logic [WIDTH-1:0] alu_res;

    alu_mul_seq #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk_i      (clk),
        .rst_i      (RESET),
        .start_i    (mul_start),
        .run_i      (mul_run),
        .a_i        (DATA1),
        .b_i        (DATA2),
        .acc_next_o (mul_acc_next),
        .last_o     (mul_last)
    );

    // Reserved opcodes (and MUL, which never reaches this path) yield zero.
    always_comb begin
        alu_res = '0;
        case (SELECT)
            OP_FWD:  alu_res = DATA2;
            OP_ADD:  alu_res = DATA1 + DATA2;
            OP_AND:  alu_res = DATA1 & DATA2;
            OP_OR:   alu_res = DATA1 | DATA2;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        dest_d    = dest_q;
        mdest_d   = mdest_q;
        valid_d   = 1'b0;
        mul_start = 1'b0;
        mul_run   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    if (SELECT == OP_MUL) begin
                        mul_start = 1'b1;
                        mdest_d   = DEST_IN;
                        state_d   = S_MUL;
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        dest_d   = DEST_IN;
                        valid_d  = 1'b1;
                    end
                end
            end
            S_MUL: begin
                mul_run = 1'b1;
                if (mul_last) begin
                    result_d = mul_acc_next;
                    zero_d   = (mul_acc_next == '0);
                    dest_d   = mdest_q;
                    valid_d  = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
            dest_q   <= '0;
            mdest_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            dest_q   <= dest_d;
            mdest_q  <= mdest_d;
            valid_q  <= valid_d;
        end
    end

    assign RESULT   = result_q;
    assign DEST_OUT = dest_q;
    assign ZERO     = zero_q;
    assign VALID    = valid_q;
    assign BUSY     = (state_q == S_MUL);

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: inputs driven and outputs sampled on the falling
// edge, expected values hand-computed.
module tb_alu_mc;

    logic       clk = 1'b0;
    logic       RESET;
    logic [7:0] DATA1, DATA2;
    logic [2:0] SELECT, DEST_IN;
    logic       START;
    logic [7:0] RESULT;
    logic [2:0] DEST_OUT;
    logic       ZERO, BUSY, VALID;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(8)) dut (
        .clk      (clk),
        .RESET    (RESET),
        .DATA1    (DATA1),
        .DATA2    (DATA2),
        .SELECT   (SELECT),
        .DEST_IN  (DEST_IN),
        .START    (START),
        .RESULT   (RESULT),
        .DEST_OUT (DEST_OUT),
        .ZERO     (ZERO),
        .BUSY     (BUSY),
        .VALID    (VALID)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [2:0] sel, input logic [7:0] a,
                         input logic [7:0] b, input logic [2:0] dst);
        START = st; SELECT = sel; DATA1 = a; DATA2 = b; DEST_IN = dst;
    endtask

    task automatic outs(input string tag, input logic [7:0] res, input logic z,
                        input logic [2:0] dst, input logic v, input logic bsy);
        check({tag, ".RESULT"},   RESULT,   res);
        check({tag, ".ZERO"},     ZERO,     z);
        check({tag, ".DEST_OUT"}, DEST_OUT, dst);
        check({tag, ".VALID"},    VALID,    v);
        check({tag, ".BUSY"},     BUSY,     bsy);
    endtask

    initial begin
        RESET = 1'b1;
        drive(1'b0, 3'b000, 8'h00, 8'h00, 3'd0);
        repeat (2) @(negedge clk);
        RESET = 1'b0;
        @(negedge clk);
        outs("reset", 8'h00, 1'b1, 3'd0, 1'b0, 1'b0);

        // ADD wraps: 0xF0 + 0x20 = 0x110 -> 0x10
        drive(1'b1, 3'b001, 8'hF0, 8'h20, 3'd5);
        @(negedge clk);
        outs("add", 8'h10, 1'b0, 3'd5, 1'b1, 1'b0);
        START = 1'b0;
        @(negedge clk);
        outs("add_hold", 8'h10, 1'b0, 3'd5, 1'b0, 1'b0);

        // Back-to-back AND then OR
        drive(1'b1, 3'b010, 8'hF0, 8'h0F, 3'd1);
        @(negedge clk);
        outs("and", 8'h00, 1'b1, 3'd1, 1'b1, 1'b0);
        drive(1'b1, 3'b011, 8'hF0, 8'h0F, 3'd2);
        @(negedge clk);
        outs("or", 8'hFF, 1'b0, 3'd2, 1'b1, 1'b0);
        START = 1'b0;
        @(negedge clk);
        check("or_after.VALID", VALID, 1'b0);

        // MUL 0x0D * 0x0B = 0x8F; operands disturbed while busy
        drive(1'b1, 3'b100, 8'h0D, 8'h0B, 3'd3);
        @(negedge clk);
        outs("mul1_start", 8'hFF, 1'b0, 3'd2, 1'b0, 1'b1);
        drive(1'b0, 3'b001, 8'hFF, 8'hFF, 3'd7);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("mul1_c%0d.BUSY", i), BUSY, 1'b1);
            check($sformatf("mul1_c%0d.VALID", i), VALID, 1'b0);
        end
        @(negedge clk);
        outs("mul1_done", 8'h8F, 1'b0, 3'd3, 1'b1, 1'b0);
        @(negedge clk);
        check("mul1_after.VALID", VALID, 1'b0);

        // MUL 0x10 * 0x10 = 0x100 -> 0x00; START pulses during BUSY ignored
        drive(1'b1, 3'b100, 8'h10, 8'h10, 3'd4);
        @(negedge clk);
        check("mul2_start.BUSY", BUSY, 1'b1);
        drive(1'b1, 3'b001, 8'h01, 8'h01, 3'd7);
        for (int i = 1; i < 8; i++) begin
            if (i == 4) START = 1'b0;
            @(negedge clk);
            check($sformatf("mul2_c%0d.VALID", i), VALID, 1'b0);
            check($sformatf("mul2_c%0d.RESULT", i), RESULT, 8'h8F);
        end
        @(negedge clk);
        outs("mul2_done", 8'h00, 1'b1, 3'd4, 1'b1, 1'b0);
        @(negedge clk);
        outs("mul2_after", 8'h00, 1'b1, 3'd4, 1'b0, 1'b0);

        // RESET during MUL cycle 4 aborts with no VALID
        drive(1'b1, 3'b100, 8'h03, 8'h05, 3'd6);
        @(negedge clk);
        START = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_pre.BUSY", BUSY, 1'b1);
        RESET = 1'b1;
        #1;
        outs("abort", 8'h00, 1'b1, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        RESET = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check($sformatf("abort_w%0d.VALID", i), VALID, 1'b0);
        end
        drive(1'b1, 3'b000, 8'h11, 8'h5A, 3'd2);
        @(negedge clk);
        outs("fwd", 8'h5A, 1'b0, 3'd2, 1'b1, 1'b0);
        START = 1'b0;
        @(negedge clk);
        check("fwd_after.VALID", VALID, 1'b0);

        // Reserved opcode writes zero
        drive(1'b1, 3'b110, 8'h12, 8'h34, 3'd1);
        @(negedge clk);
        outs("rsvd", 8'h00, 1'b1, 3'd1, 1'b1, 1'b0);
        START = 1'b0;
        @(negedge clk);
        outs("rsvd_after", 8'h00, 1'b1, 3'd1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
